mod_segment_serializer: RTL and testbench



---
 rtl/mod_unroll_pkg.sv | 16 +
 rtl/mod_seg_fifo.sv | 48 ++++
 rtl/mod_segment_serializer.sv | 112 +++++++++++
 tb/tb_mod_segment_serializer.sv | 370 +++++++++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/mod_unroll_pkg.sv
// Shared constants for the unrolled modulation chain back end.
package mod_unroll_pkg;

  localparam int DATA_W         = 32;
  localparam int SYM_W          = 2;
  localparam int SYMS_PER_SEG   = DATA_W / SYM_W;
  localparam int SEGS_PER_FRAME = 10;
  localparam int FCNT_W         = 16;
  localparam int SEG_FIFO_DEPTH = 4;

  // Index width for a counter spanning 0..n-1; never narrower than one bit.
  function automatic int idx_w(input int n);
    return (n > 1) ? $clog2(n) : 1;
  endfunction

endpackage

// File: rtl/mod_seg_fifo.sv
// Small synchronous FIFO for combined segment words. Push is ignored when
// full and pop when empty, so callers may hold the strobes loosely.
module mod_seg_fifo #(
  parameter int W     = 32,
  parameter int DEPTH = 4
) (
  input  logic         clk,
  input  logic         reset,
  input  logic         push_i,
  input  logic [W-1:0] wdata_i,
  input  logic         pop_i,
  output logic [W-1:0] rdata_o,
  output logic         full_o,
  output logic         empty_o
);

  localparam int AW = (DEPTH > 1) ? $clog2(DEPTH) : 1;

  logic [W-1:0]  mem_q [DEPTH];
  logic [AW-1:0] wr_q, rd_q;
  logic [AW:0]   cnt_q;
  logic          push_ok, pop_ok;

  assign full_o  = (cnt_q == (AW+1)'(DEPTH));
  assign empty_o = (cnt_q == '0);
  assign push_ok = push_i & ~full_o;
  assign pop_ok  = pop_i & ~empty_o;
  assign rdata_o = mem_q[rd_q];

  // Storage: data needs no reset, the count decides what is valid.
  always_ff @(posedge clk) begin
    if (push_ok) mem_q[wr_q] <= wdata_i;
  end

  // Pointers wrap naturally at DEPTH (power of two); count tracks occupancy.
  always_ff @(posedge clk) begin
    if (!reset) begin
      wr_q  <= '0;
      rd_q  <= '0;
      cnt_q <= '0;
    end else begin
      if (push_ok) wr_q <= wr_q + 1'b1;
      if (pop_ok)  rd_q <= rd_q + 1'b1;
      cnt_q <= cnt_q + {{AW{1'b0}}, push_ok} - {{AW{1'b0}}, pop_ok};
    end
  end

endmodule

// File: rtl/mod_segment_serializer.sv
// Buffers combined segment words and emits them LSB-first as SYM_W-bit
// symbols, tagging frame start/end and counting completed frames.
module mod_segment_serializer #(
  parameter int DATA_W         = mod_unroll_pkg::DATA_W,
  parameter int SYM_W          = mod_unroll_pkg::SYM_W,
  parameter int DEPTH          = mod_unroll_pkg::SEG_FIFO_DEPTH,
  parameter int SEGS_PER_FRAME = mod_unroll_pkg::SEGS_PER_FRAME
) (
  input  logic              clk,
  input  logic              reset,
  input  logic [DATA_W-1:0] seg_data,
  input  logic              seg_valid,
  output logic              seg_ready,
  output logic [SYM_W-1:0]  sym_data,
  output logic              sym_valid,
  input  logic              sym_ready,
  output logic              sym_sof,
  output logic              sym_eof,
  output logic [15:0]       frame_count
);

  import mod_unroll_pkg::*;

  localparam int SYMS = DATA_W / SYM_W;
  localparam int IW   = idx_w(SYMS);
  localparam int SW   = idx_w(SEGS_PER_FRAME);
  localparam logic [IW-1:0] IDX_LAST = IW'(SYMS - 1);
  localparam logic [SW-1:0] SEG_LAST = SW'(SEGS_PER_FRAME - 1);

  logic              fifo_full, fifo_empty;
  logic [DATA_W-1:0] fifo_rdata;
  logic              push, pop, fire, last_sym, seg_wrap;

  logic              loaded_q, loaded_d;
  logic [DATA_W-1:0] word_q, word_d;
  logic [IW-1:0]     idx_q, idx_d;
  logic [SW-1:0]     seg_q, seg_d;
  logic [FCNT_W-1:0] frame_cnt_q, frame_cnt_d;

  // Input side: no bypass, so the FIFO alone decides acceptance.
  assign seg_ready = reset & ~fifo_full;
  assign push      = seg_valid & seg_ready;

  assign fire     = loaded_q & sym_ready;
  assign last_sym = (idx_q == IDX_LAST);
  assign seg_wrap = (seg_q == SEG_LAST);
  // Refill when idle, or on the last-symbol handshake to avoid a bubble.
  assign pop      = ~fifo_empty & (~loaded_q | (fire & last_sym));

  mod_seg_fifo #(
    .W     (DATA_W),
    .DEPTH (DEPTH)
  ) u_fifo (
    .clk     (clk),
    .reset   (reset),
    .push_i  (push),
    .wdata_i (seg_data),
    .pop_i   (pop),
    .rdata_o (fifo_rdata),
    .full_o  (fifo_full),
    .empty_o (fifo_empty)
  );

  // Shifter, segment position and frame counter next-state.
  always_comb begin
    loaded_d    = loaded_q;
    word_d      = word_q;
    idx_d       = idx_q;
    seg_d       = seg_q;
    frame_cnt_d = frame_cnt_q;
    if (fire) begin
      if (last_sym) begin
        idx_d    = '0;
        loaded_d = 1'b0;
        seg_d    = seg_wrap ? '0 : seg_q + 1'b1;
        if (seg_wrap) frame_cnt_d = frame_cnt_q + 1'b1;
      end else begin
        idx_d = idx_q + 1'b1;
      end
    end
    if (pop) begin
      word_d   = fifo_rdata;
      loaded_d = 1'b1;
      idx_d    = '0;
    end
  end

  // State registers; reset drops any partially sent word.
  always_ff @(posedge clk) begin
    if (!reset) begin
      loaded_q    <= 1'b0;
      word_q      <= '0;
      idx_q       <= '0;
      seg_q       <= '0;
      frame_cnt_q <= '0;
    end else begin
      loaded_q    <= loaded_d;
      word_q      <= word_d;
      idx_q       <= idx_d;
      seg_q       <= seg_d;
      frame_cnt_q <= frame_cnt_d;
    end
  end

  // Outputs are pure functions of registered state, so they hold under stall.
  assign sym_valid   = loaded_q;
  assign sym_data    = word_q[SYM_W*idx_q +: SYM_W];
  assign sym_sof     = loaded_q & (seg_q == '0) & (idx_q == '0);
  assign sym_eof     = loaded_q & seg_wrap & last_sym;
  assign frame_count = frame_cnt_q;

endmodule

// File: tb/tb_mod_segment_serializer.sv
// Randomized bench for mod_segment_serializer against a symbol-stream model.
module tb_mod_segment_serializer;

  logic        clk = 1'b0;
  logic        reset;
  logic [31:0] seg_data;
  logic        seg_valid;
  logic        seg_ready;
  logic [1:0]  sym_data;
  logic        sym_valid;
  logic        sym_ready;
  logic        sym_sof;
  logic        sym_eof;
  logic [15:0] frame_count;

  always #5 clk = ~clk;

  mod_segment_serializer dut (
    .clk         (clk),
    .reset       (reset),
    .seg_data    (seg_data),
    .seg_valid   (seg_valid),
    .seg_ready   (seg_ready),
    .sym_data    (sym_data),
    .sym_valid   (sym_valid),
    .sym_ready   (sym_ready),
    .sym_sof     (sym_sof),
    .sym_eof     (sym_eof),
    .frame_count (frame_count)
  );

  typedef struct packed {
    logic [1:0] d;
    logic       sof;
    logic       eof;
  } sym_t;

  int checks = 0;
  int errors = 0;

  // Reference model: every accepted word expands to 16 expected symbols.
  sym_t        exp_q[$];
  sym_t        exp_cur;
  int          words_acc;
  logic [15:0] exp_fc;
  logic [31:0] in_q[$];
  logic        feed_en, feed_gate;

  // Snapshot of the DUT taken mid-cycle.
  logic [1:0]  o_data;
  logic        o_valid, o_sof, o_eof, o_segrdy, pushed, consumed;
  logic [15:0] o_fc;

  task automatic add_word(input logic [31:0] w);
    sym_t s;
    for (int i = 0; i < 16; i++) begin
      s.d   = w[2*i +: 2];
      s.sof = (words_acc % 10 == 0) && (i == 0);
      s.eof = (words_acc % 10 == 9) && (i == 15);
      exp_q.push_back(s);
    end
    words_acc++;
  endtask

  task automatic model_clear();
    exp_q.delete();
    in_q.delete();
    words_acc = 0;
    exp_fc    = 16'd0;
  endtask

  // One clock: drive from the feed queue, sample at negedge, step the model.
  task automatic cycle();
    logic [31:0] tmp;
    if (feed_en) begin
      seg_valid = (in_q.size() > 0) && feed_gate;
      seg_data  = (in_q.size() > 0) ? in_q[0] : 32'h0;
    end
    @(negedge clk);
    o_data   = sym_data;
    o_valid  = sym_valid;
    o_sof    = sym_sof;
    o_eof    = sym_eof;
    o_segrdy = seg_ready;
    o_fc     = frame_count;
    pushed   = seg_valid & seg_ready;
    consumed = sym_valid & sym_ready;
    if (consumed) begin
      if (exp_q.size() > 0) exp_cur = exp_q.pop_front();
      else                  exp_cur = 'x;
      if (exp_cur.eof === 1'b1) exp_fc = exp_fc + 16'd1;
    end
    if (pushed) begin
      add_word(seg_data);
      if (feed_en && in_q.size() > 0) tmp = in_q.pop_front();
    end
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    reset     = 1'b0;
    seg_valid = 1'b0;
    seg_data  = 32'h0;
    sym_ready = 1'b0;
    feed_en   = 1'b0;
    feed_gate = 1'b1;
    repeat (2) @(posedge clk);
    #1;
    reset = 1'b1;
    model_clear();
  endtask

  task automatic test_reset();
    reset     = 1'b0;
    seg_valid = 1'b1;
    seg_data  = 32'hDEAD_BEEF;
    sym_ready = 1'b1;
    repeat (2) @(posedge clk);
    @(negedge clk);
    checks++; if (sym_valid !== 1'b0)    begin errors++; $display("FAIL reset_valid got %0b want 0", sym_valid); end
    checks++; if (sym_sof !== 1'b0)      begin errors++; $display("FAIL reset_sof got %0b want 0", sym_sof); end
    checks++; if (sym_eof !== 1'b0)      begin errors++; $display("FAIL reset_eof got %0b want 0", sym_eof); end
    checks++; if (frame_count !== 16'd0) begin errors++; $display("FAIL reset_fc got %0d want 0", frame_count); end
    checks++; if (seg_ready !== 1'b0)    begin errors++; $display("FAIL reset_segrdy got %0b want 0", seg_ready); end
    do_reset();
    @(negedge clk);
    checks++; if (seg_ready !== 1'b1)    begin errors++; $display("FAIL post_reset_segrdy got %0b want 1", seg_ready); end
    @(posedge clk); #1;
  endtask

  task automatic test_first_word();
    do_reset();
    sym_ready = 1'b1;
    seg_valid = 1'b1;
    seg_data  = 32'h1B1B_1B1B;
    cycle();
    checks++; if (pushed !== 1'b1) begin errors++; $display("FAIL first_push got %0b want 1", pushed); end
    seg_valid = 1'b0;
    cycle();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL first_latency_n1 got %0b want 0", o_valid); end
    for (int i = 0; i < 16; i++) begin
      cycle();
      checks++;
      if (!consumed || {o_data, o_sof, o_eof} !== exp_cur) begin
        errors++; $display("FAIL first_sym%0d got v%0b d%0d s%0b e%0b want %h", i, o_valid, o_data, o_sof, o_eof, exp_cur);
      end
      checks++;
      if (o_data !== 2'(3 - (i % 4))) begin
        errors++; $display("FAIL first_pattern%0d got %0d want %0d", i, o_data, 3 - (i % 4));
      end
    end
    cycle();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL first_drain got %0b want 0", o_valid); end
  endtask

  task automatic test_frame();
    int got = 0, gaps = 0;
    do_reset();
    sym_ready = 1'b1;
    feed_en   = 1'b1;
    for (int i = 0; i < 10; i++) in_q.push_back($urandom);
    for (int c = 0; c < 400 && got < 160; c++) begin
      cycle();
      if (consumed) begin
        got++;
        checks++;
        if ({o_data, o_sof, o_eof} !== exp_cur) begin
          errors++; $display("FAIL frame_sym%0d got d%0d s%0b e%0b want %h", got, o_data, o_sof, o_eof, exp_cur);
        end
        if (got == 160) begin
          checks++; if (o_fc !== 16'd0) begin errors++; $display("FAIL frame_fc_before got %0d want 0", o_fc); end
        end
      end else if (got > 0) gaps++;
    end
    checks++; if (got !== 160) begin errors++; $display("FAIL frame_count_syms got %0d want 160", got); end
    checks++; if (gaps !== 0)  begin errors++; $display("FAIL frame_gaps got %0d want 0", gaps); end
    cycle();
    checks++; if (o_fc !== 16'd1) begin errors++; $display("FAIL frame_fc_after got %0d want 1", o_fc); end
    feed_en = 1'b0;
  endtask

  task automatic test_backpressure();
    int acc = 0, n = 0, drained = 0;
    logic [3:0] held;
    logic       have = 1'b0, stable = 1'b1;
    do_reset();
    sym_ready = 1'b0;
    for (int c = 0; c < 10; c++) begin
      seg_valid = 1'b1;
      seg_data  = $urandom;
      cycle();
      if (pushed) acc++;
      if (o_valid) begin
        if (!have) begin held = {o_data, o_sof, o_eof}; have = 1'b1; end
        else if ({o_data, o_sof, o_eof} !== held) stable = 1'b0;
      end
    end
    seg_valid = 1'b0;
    checks++; if (acc !== 5)        begin errors++; $display("FAIL bp_accepted got %0d want 5", acc); end
    checks++; if (o_segrdy !== 1'b0) begin errors++; $display("FAIL bp_segrdy got %0b want 0", o_segrdy); end
    checks++; if (!have || !stable || held[1] !== 1'b1) begin
      errors++; $display("FAIL bp_stable got have%0b stable%0b sof%0b want 1 1 1", have, stable, held[1]);
    end
    sym_ready = 1'b1;
    for (int c = 0; c < 40; c++) begin
      cycle();
      if (o_segrdy) break;
      if (consumed) begin
        n++;
        checks++;
        if ({o_data, o_sof, o_eof} !== exp_cur) begin
          errors++; $display("FAIL bp_sym%0d got d%0d want %h", n, o_data, exp_cur);
        end
      end
    end
    checks++; if (n !== 16) begin errors++; $display("FAIL bp_reopen got %0d syms want 16", n); end
    for (int c = 0; c < 200 && (exp_q.size() > 0 || o_valid); c++) begin
      cycle();
      if (consumed) begin
        drained++;
        checks++;
        if ({o_data, o_sof, o_eof} !== exp_cur) begin
          errors++; $display("FAIL bp_drain%0d got d%0d want %h", drained, o_data, exp_cur);
        end
      end
    end
    checks++; if (exp_q.size() != 0) begin errors++; $display("FAIL bp_leftover got %0d want 0", exp_q.size()); end
  endtask

  task automatic test_toggle_ready();
    int got = 0;
    do_reset();
    feed_en = 1'b1;
    for (int i = 0; i < 3; i++) in_q.push_back($urandom);
    for (int c = 0; c < 300 && got < 48; c++) begin
      sym_ready = c[0];
      cycle();
      if (consumed) begin
        got++;
        checks++;
        if ({o_data, o_sof, o_eof} !== exp_cur) begin
          errors++; $display("FAIL toggle_sym%0d got d%0d s%0b e%0b want %h", got, o_data, o_sof, o_eof, exp_cur);
        end
      end
    end
    checks++; if (got !== 48 || exp_q.size() != 0) begin
      errors++; $display("FAIL toggle_total got %0d left %0d want 48 0", got, exp_q.size());
    end
    feed_en = 1'b0;
  endtask

  task automatic test_random();
    int got = 0;
    do_reset();
    feed_en = 1'b1;
    for (int i = 0; i < 25; i++) in_q.push_back($urandom);
    for (int c = 0; c < 2000 && (in_q.size() > 0 || exp_q.size() > 0); c++) begin
      sym_ready = ($urandom_range(0, 3) != 0);
      feed_gate = ($urandom_range(0, 2) != 0);
      cycle();
      if (consumed) begin
        got++;
        checks++;
        if ({o_data, o_sof, o_eof} !== exp_cur) begin
          errors++; $display("FAIL rand_sym%0d got d%0d s%0b e%0b want %h", got, o_data, o_sof, o_eof, exp_cur);
        end
      end
    end
    cycle();
    checks++; if (got !== 400)    begin errors++; $display("FAIL rand_total got %0d want 400", got); end
    checks++; if (o_fc !== exp_fc) begin errors++; $display("FAIL rand_fc got %0d want %0d", o_fc, exp_fc); end
    feed_en   = 1'b0;
    feed_gate = 1'b1;
  endtask

  task automatic test_midframe_reset();
    int got = 0;
    do_reset();
    sym_ready = 1'b1;
    feed_en   = 1'b1;
    for (int i = 0; i < 6; i++) in_q.push_back($urandom);
    for (int c = 0; c < 200 && got < 55; c++) begin
      cycle();
      if (consumed) got++;
    end
    feed_en   = 1'b0;
    seg_valid = 1'b0;
    sym_ready = 1'b0;
    @(negedge clk);
    checks++; if (sym_valid !== 1'b1) begin errors++; $display("FAIL mid_pre_valid got %0b want 1", sym_valid); end
    @(posedge clk); #1;
    reset = 1'b0;
    cycle();
    model_clear();
    reset = 1'b1;
    cycle();
    checks++; if (o_valid !== 1'b0) begin errors++; $display("FAIL mid_valid got %0b want 0", o_valid); end
    checks++; if (o_fc !== 16'd0)   begin errors++; $display("FAIL mid_fc got %0d want 0", o_fc); end
    sym_ready = 1'b1;
    feed_en   = 1'b1;
    in_q.push_back($urandom);
    got = 0;
    for (int c = 0; c < 40 && got < 16; c++) begin
      cycle();
      if (consumed) begin
        got++;
        checks++;
        if ({o_data, o_sof, o_eof} !== exp_cur || (got == 1 && o_sof !== 1'b1)) begin
          errors++; $display("FAIL mid_sym%0d got d%0d s%0b want %h", got, o_data, o_sof, exp_cur);
        end
      end
    end
    feed_en = 1'b0;
    repeat (3) cycle();
    checks++; if (o_valid !== 1'b0 || got !== 16) begin
      errors++; $display("FAIL mid_stale got valid%0b syms%0d want 0 16", o_valid, got);
    end
  endtask

  task automatic test_fc_wrap();
    int got = 0;
    do_reset();
    force dut.frame_cnt_q = 16'hFFFF;
    cycle();
    release dut.frame_cnt_q;
    exp_fc = 16'hFFFF;
    cycle();
    checks++; if (o_fc !== 16'hFFFF) begin errors++; $display("FAIL wrap_preload got %h want ffff", o_fc); end
    sym_ready = 1'b1;
    feed_en   = 1'b1;
    for (int i = 0; i < 10; i++) in_q.push_back($urandom);
    for (int c = 0; c < 400 && got < 160; c++) begin
      cycle();
      if (consumed) begin
        got++;
        checks++;
        if ({o_data, o_sof, o_eof} !== exp_cur) begin
          errors++; $display("FAIL wrap_sym%0d got d%0d want %h", got, o_data, exp_cur);
        end
      end
    end
    cycle();
    checks++; if (o_fc !== 16'h0000 || exp_fc !== 16'h0000) begin
      errors++; $display("FAIL wrap_fc got %h model %h want 0000", o_fc, exp_fc);
    end
    feed_en = 1'b0;
  endtask

  initial begin
    reset     = 1'b0;
    seg_valid = 1'b0;
    seg_data  = 32'h0;
    sym_ready = 1'b0;
    feed_en   = 1'b0;
    feed_gate = 1'b1;
    model_clear();
    test_reset();
    test_first_word();
    test_frame();
    test_backpressure();
    test_toggle_ready();
    test_random();
    test_midframe_reset();
    test_fc_wrap();
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
